carrier_nco: RTL and testbench

//  Carrier NCO closing the carrier loop. Sums center frequency, loop-filter lag offset and optional lead term into a
//  32-bit frequency word, integrates it into a phase accumulator, and produces quadrature sin/cos from a quarter-wave LUT
//  for the downconverter mixer. Also exports the 12-bit phase used by the demod phase detectors.

---
 rtl/carrier_nco.sv | 171 +++++++++++++++++
 tb/tb_carrier_nco.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_nco.sv
// Carrier NCO: frequency word assembly, 32-bit phase accumulator and quadrature
// sin/cos generation from a quarter-wave ROM, three pipeline stages deep.
module carrier_nco #(
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clkEn,
  input  logic [PHASE_W-1:0]      centerFreq,
  input  logic [PHASE_W-1:0]      carrierFreqOffset,
  input  logic [PHASE_W-1:0]      carrierLeadFreq,
  input  logic                    carrierFreqEn,
  input  logic                    leadEnable,
  input  logic                    freqHold,
  input  logic                    phaseClear,
  output logic [11:0]             ncoPhase,
  output logic signed [OUT_W-1:0] sinOut,
  output logic signed [OUT_W-1:0] cosOut,
  output logic                    outValid
);

  localparam int MAG_W     = OUT_W - 1;
  localparam int LUT_DEPTH = 1 << LUT_ADDR_W;
  localparam int AMP       = (1 << (OUT_W - 1)) - 1;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            sin_quad;
    logic [1:0]            cos_quad;
    logic [LUT_ADDR_W-1:0] frac;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sin_neg;
    logic             cos_neg;
    logic [MAG_W-1:0] sin_mag;
    logic [MAG_W-1:0] cos_mag;
  } s2_t;

  // Sample points sit half an LSB into each bin, so odd quadrants mirror exactly
  // with ~addr and no entry is zero or needs a sign.
  function automatic logic [MAG_W-1:0] lut_entry(input int k);
    real x;
    real term;
    real acc;
    x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_DEPTH);
    term = x;
    acc  = x;
    for (int n = 1; n <= 9; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return MAG_W'($rtoi(acc * real'(AMP) + 0.5));
  endfunction

  function automatic logic [LUT_ADDR_W-1:0] mirror_addr(input logic odd_quad,
                                                         input logic [LUT_ADDR_W-1:0] frac);
    return odd_quad ? ~frac : frac;
  endfunction

  function automatic logic signed [OUT_W-1:0] apply_sign(input logic [MAG_W-1:0] mag,
                                                          input logic neg);
    logic signed [OUT_W-1:0] v;
    v = signed'({1'b0, mag});
    return neg ? -v : v;
  endfunction

  // NOTE: the ROM is pure constants fixed at elaboration; it holds no state, so
  // only the pipeline flops around it take reset.
  logic [MAG_W-1:0] lut_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [MAG_W-1:0] ENTRY = lut_entry(k);
    assign lut_rom[k] = ENTRY;
  end

  logic [PHASE_W-1:0]      lag_q, lag_d;
  logic [PHASE_W-1:0]      lead_q, lead_d;
  logic [PHASE_W-1:0]      freq_word_q, freq_word_d;
  logic [PHASE_W-1:0]      phase_acc_q, phase_acc_d;
  s1_t                     s1_q, s1_d;
  s2_t                     s2_q, s2_d;
  logic signed [OUT_W-1:0] sin_out_q, sin_out_d;
  logic signed [OUT_W-1:0] cos_out_q, cos_out_d;
  logic                    out_valid_q, out_valid_d;
  logic [LUT_ADDR_W-1:0]   sin_addr, cos_addr;

  always_comb begin
    // NOTE: every combinational output gets its default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    lag_d       = lag_q;
    lead_d      = lead_q;
    phase_acc_d = phase_acc_q;

    if (carrierFreqEn && !freqHold) begin
      lag_d  = carrierFreqOffset;
      lead_d = carrierLeadFreq;
    end

    freq_word_d = centerFreq + lag_q + (leadEnable ? lead_q : '0);

    // Clear wins over advance and does not need the sample enable.
    if (phaseClear) begin
      phase_acc_d = '0;
    end else if (clkEn) begin
      phase_acc_d = phase_acc_q + freq_word_q;
    end
  end

  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = clkEn;
    if (clkEn) begin
      s1_d.sin_quad = phase_acc_q[PHASE_W-1 -: 2];
      s1_d.cos_quad = phase_acc_q[PHASE_W-1 -: 2] + 2'd1;
      s1_d.frac     = phase_acc_q[PHASE_W-3 -: LUT_ADDR_W];
    end

    sin_addr     = mirror_addr(s1_q.sin_quad[0], s1_q.frac);
    cos_addr     = mirror_addr(s1_q.cos_quad[0], s1_q.frac);
    s2_d.valid   = s1_q.valid;
    s2_d.sin_neg = s1_q.sin_quad[1];
    s2_d.cos_neg = s1_q.cos_quad[1];
    s2_d.sin_mag = lut_rom[sin_addr];
    s2_d.cos_mag = lut_rom[cos_addr];

    // Outputs hold their last sample between valid strobes.
    sin_out_d   = sin_out_q;
    cos_out_d   = cos_out_q;
    out_valid_d = s2_q.valid;
    if (s2_q.valid) begin
      sin_out_d = apply_sign(s2_q.sin_mag, s2_q.sin_neg);
      cos_out_d = apply_sign(s2_q.cos_mag, s2_q.cos_neg);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lag_q       <= '0;
      lead_q      <= '0;
      freq_word_q <= '0;
      phase_acc_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      sin_out_q   <= '0;
      cos_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // which is what lets S1 capture the phase before this edge's update.
      lag_q       <= lag_d;
      lead_q      <= lead_d;
      freq_word_q <= freq_word_d;
      phase_acc_q <= phase_acc_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      sin_out_q   <= sin_out_d;
      cos_out_q   <= cos_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ncoPhase = phase_acc_q[PHASE_W-1 -: 12];
  assign sinOut   = sin_out_q;
  assign cosOut   = cos_out_q;
  assign outValid = out_valid_q;

endmodule

// File: tb/tb_carrier_nco.sv
// Directed bench for carrier_nco: a per-cycle vector table for the phase and
// sin/cos pipeline, plus hand sequences for offsets, wrap and mid-run reset.
module tb_carrier_nco;

  localparam int OUT_W = 18;

  logic                    clk;
  logic                    reset;
  logic                    clkEn;
  logic [31:0]             centerFreq;
  logic [31:0]             carrierFreqOffset;
  logic [31:0]             carrierLeadFreq;
  logic                    carrierFreqEn;
  logic                    leadEnable;
  logic                    freqHold;
  logic                    phaseClear;
  logic [11:0]             ncoPhase;
  logic signed [OUT_W-1:0] sinOut;
  logic signed [OUT_W-1:0] cosOut;
  logic                    outValid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] center;
    logic        clk_en;
    logic        phase_clear;
    logic [11:0] exp_nco;
    logic        exp_valid;
    int          exp_sin;
    int          exp_cos;
  } vec_t;

  vec_t vecs[$];

  carrier_nco dut (
    .clk               (clk),
    .reset             (reset),
    .clkEn             (clkEn),
    .centerFreq        (centerFreq),
    .carrierFreqOffset (carrierFreqOffset),
    .carrierLeadFreq   (carrierLeadFreq),
    .carrierFreqEn     (carrierFreqEn),
    .leadEnable        (leadEnable),
    .freqHold          (freqHold),
    .phaseClear        (phaseClear),
    .ncoPhase          (ncoPhase),
    .sinOut            (sinOut),
    .cosOut            (cosOut),
    .outValid          (outValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t mk(input logic [31:0] center, input logic en, input logic clr,
                              input logic [11:0] nco, input logic vld, input int s, input int c);
    vec_t v;
    v.center      = center;
    v.clk_en      = en;
    v.phase_clear = clr;
    v.exp_nco     = nco;
    v.exp_valid   = vld;
    v.exp_sin     = s;
    v.exp_cos     = c;
    return v;
  endfunction

  localparam logic [31:0] F90 = 32'h4000_0000;
  localparam logic [31:0] F45 = 32'h2000_0000;

  initial begin
    // Quarter-turn steps: exact quadrant points, clear with and without clkEn.
    vecs.push_back(mk(F90, 1'b1, 1'b0, 12'h400, 1'b0,       0,       0));
    vecs.push_back(mk(F90, 1'b0, 1'b0, 12'h400, 1'b0,       0,       0));
    vecs.push_back(mk(F90, 1'b1, 1'b0, 12'h800, 1'b1,     101,  131071));
    vecs.push_back(mk(F90, 1'b1, 1'b0, 12'hC00, 1'b0,     101,  131071));
    vecs.push_back(mk(F90, 1'b1, 1'b1, 12'h000, 1'b1,  131071,    -101));
    vecs.push_back(mk(F90, 1'b0, 1'b0, 12'h000, 1'b1,    -101, -131071));
    vecs.push_back(mk(F90, 1'b0, 1'b0, 12'h000, 1'b1, -131071,     101));
    vecs.push_back(mk(F90, 1'b0, 1'b0, 12'h000, 1'b0, -131071,     101));
    vecs.push_back(mk(F90, 1'b1, 1'b0, 12'h400, 1'b0, -131071,     101));
    vecs.push_back(mk(F90, 1'b1, 1'b0, 12'h800, 1'b0, -131071,     101));
    vecs.push_back(mk(F90, 1'b0, 1'b1, 12'h000, 1'b1,     101,  131071));
    vecs.push_back(mk(F90, 1'b0, 1'b0, 12'h000, 1'b1,  131071,    -101));
    vecs.push_back(mk(F90, 1'b0, 1'b0, 12'h000, 1'b0,  131071,    -101));
    // Eighth-turn steps: mid-quadrant points exercise mirroring of non-zero addresses.
    vecs.push_back(mk(F45, 1'b0, 1'b1, 12'h000, 1'b0,  131071,    -101));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'h200, 1'b0,  131071,    -101));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'h400, 1'b0,  131071,    -101));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'h600, 1'b1,     101,  131071));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'h800, 1'b1,   92752,   92610));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'hA00, 1'b1,  131071,    -101));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'hC00, 1'b1,   92610,  -92752));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'hE00, 1'b1,    -101, -131071));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'h000, 1'b1,  -92752,  -92610));
    vecs.push_back(mk(F45, 1'b1, 1'b0, 12'h200, 1'b1, -131071,     101));
    vecs.push_back(mk(F45, 1'b0, 1'b0, 12'h200, 1'b1,  -92610,   92752));
    vecs.push_back(mk(F45, 1'b0, 1'b0, 12'h200, 1'b1,     101,  131071));
    vecs.push_back(mk(F45, 1'b0, 1'b0, 12'h200, 1'b0,     101,  131071));

    reset             = 1'b1;
    clkEn             = 1'b0;
    centerFreq        = '0;
    carrierFreqOffset = '0;
    carrierLeadFreq   = '0;
    carrierFreqEn     = 1'b0;
    leadEnable        = 1'b0;
    freqHold          = 1'b0;
    phaseClear        = 1'b0;
    tick(3);
    check("reset sinOut", sinOut, 0);
    check("reset cosOut", cosOut, 0);
    check("reset outValid", outValid, 0);
    check("reset ncoPhase", ncoPhase, 0);
    check("reset freqWord", dut.freq_word_q, 0);

    reset      = 1'b0;
    centerFreq = F90;
    tick(2);

    foreach (vecs[i]) begin
      centerFreq = vecs[i].center;
      clkEn      = vecs[i].clk_en;
      phaseClear = vecs[i].phase_clear;
      tick(1);
      check($sformatf("vec%0d ncoPhase", i), ncoPhase, vecs[i].exp_nco);
      check($sformatf("vec%0d outValid", i), outValid, vecs[i].exp_valid);
      check($sformatf("vec%0d sinOut", i), sinOut, vecs[i].exp_sin);
      check($sformatf("vec%0d cosOut", i), cosOut, vecs[i].exp_cos);
    end
    clkEn      = 1'b0;
    phaseClear = 1'b0;

    // Offset latch timing, hold, lead enable and negative offsets.
    centerFreq = F90;
    tick(2);
    check("fw center only", dut.freq_word_q, 32'h4000_0000);
    carrierFreqOffset = 32'h0010_0000;
    carrierLeadFreq   = 32'h0000_0100;
    carrierFreqEn     = 1'b1;
    tick(1);
    check("fw strobe+1 unchanged", dut.freq_word_q, 32'h4000_0000);
    carrierFreqEn     = 1'b0;
    carrierFreqOffset = 32'h0555_0000;
    carrierLeadFreq   = 32'h0000_0777;
    tick(1);
    check("fw strobe+2 lag", dut.freq_word_q, 32'h4010_0000);
    tick(1);
    check("fw no relatch", dut.freq_word_q, 32'h4010_0000);
    freqHold          = 1'b1;
    carrierFreqEn     = 1'b1;
    carrierFreqOffset = 32'h0020_0000;
    carrierLeadFreq   = 32'h0000_0999;
    tick(2);
    check("fw under hold", dut.freq_word_q, 32'h4010_0000);
    carrierFreqEn = 1'b0;
    freqHold      = 1'b0;
    leadEnable    = 1'b1;
    tick(1);
    check("fw lead on", dut.freq_word_q, 32'h4010_0100);
    leadEnable = 1'b0;
    tick(1);
    check("fw lead off", dut.freq_word_q, 32'h4010_0000);
    carrierFreqOffset = 32'hFFF0_0000;
    carrierLeadFreq   = 32'hFFFF_FF00;
    carrierFreqEn     = 1'b1;
    tick(1);
    carrierFreqEn = 1'b0;
    tick(1);
    check("fw negative lag", dut.freq_word_q, 32'h3FF0_0000);
    leadEnable = 1'b1;
    tick(1);
    check("fw negative lead", dut.freq_word_q, 32'h3FEF_FF00);
    leadEnable = 1'b0;

    // Accumulator wrap near 2^32.
    centerFreq        = 32'hFFFF_FFF0;
    carrierFreqOffset = '0;
    carrierLeadFreq   = '0;
    carrierFreqEn     = 1'b1;
    tick(1);
    carrierFreqEn = 1'b0;
    tick(1);
    check("fw wrap setup", dut.freq_word_q, 32'hFFFF_FFF0);
    phaseClear = 1'b1;
    tick(1);
    phaseClear = 1'b0;
    check("acc cleared", dut.phase_acc_q, 0);
    clkEn = 1'b1;
    tick(1);
    check("acc first step", dut.phase_acc_q, 32'hFFFF_FFF0);
    check("nco first step", ncoPhase, 12'hFFF);
    clkEn      = 1'b0;
    centerFreq = 32'hFFFF_FFFF;
    tick(1);
    check("acc held no clkEn", dut.phase_acc_q, 32'hFFFF_FFF0);
    clkEn = 1'b1;
    tick(1);
    check("acc wrapped", dut.phase_acc_q, 32'hFFFF_FFEF);
    check("nco after wrap", ncoPhase, 12'hFFF);
    tick(1);
    check("nco second wrap", ncoPhase, 12'hFFF);
    clkEn = 1'b0;

    // Reset while the pipeline is busy flushes it.
    centerFreq = F90;
    phaseClear = 1'b1;
    tick(1);
    phaseClear = 1'b0;
    tick(1);
    clkEn = 1'b1;
    tick(4);
    check("busy outValid", outValid, 1);
    check("busy sinOut", sinOut, 131071);
    #2;
    reset = 1'b1;
    clkEn = 1'b0;
    #1;
    check("async reset sinOut", sinOut, 0);
    check("async reset cosOut", cosOut, 0);
    check("async reset outValid", outValid, 0);
    check("async reset ncoPhase", ncoPhase, 0);
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("post reset idle%0d outValid", i), outValid, 0);
    end
    clkEn = 1'b1;
    tick(1);
    clkEn = 1'b0;
    check("post reset nco", ncoPhase, 12'h400);
    check("post reset n+1 outValid", outValid, 0);
    tick(1);
    check("post reset n+2 outValid", outValid, 0);
    tick(1);
    check("post reset n+3 outValid", outValid, 1);
    check("post reset sinOut", sinOut, 101);
    check("post reset cosOut", cosOut, 131071);
    tick(1);
    check("post reset n+4 outValid", outValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
